branch_predictor_btb: RTL and testbench

//  Parametrised branch target buffer with per-entry saturating direction counters, for the IF stage.

---
 rtl/bpred_pkg.sv | 53 +++++
 rtl/bpred_sat_ctr.sv | 48 ++++
 rtl/branch_predictor_btb.sv | 207 ++++++++++++++++++++
 tb/tb_branch_predictor_btb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpred_pkg
// Purpose  : Shared types, mode selectors and saturating-counter helpers for
//            the branch target buffer and its per-entry direction counters.
// Revision : 1.0  initial release
// ============================================================================
package bpred_pkg;

  // Indexing modes
  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Widest direction counter the helper functions support
  localparam int CTR_MAX_W = 8;

  // Invalidation sweep controller states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } bp_state_e;

  // All-ones value for a w-bit counter
  function automatic logic [CTR_MAX_W-1:0] ctr_max(input int unsigned w);
    return CTR_MAX_W'((1 << w) - 1);
  endfunction

  // Weakly taken: MSB set, everything else clear (10 for 2 bits)
  function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int unsigned w);
    return CTR_MAX_W'(1 << (w - 1));
  endfunction

  // Weakly not-taken: just below the taken threshold (01 for 2 bits)
  function automatic logic [CTR_MAX_W-1:0] ctr_weak_nt(input int unsigned w);
    return CTR_MAX_W'((1 << (w - 1)) - 1);
  endfunction

  // Increment, holding at the w-bit maximum
  function automatic logic [CTR_MAX_W-1:0] ctr_inc(input logic [CTR_MAX_W-1:0] v,
                                                   input int unsigned w);
    if (v >= ctr_max(w)) return v;
    return v + CTR_MAX_W'(1);
  endfunction

  // Decrement, holding at zero
  function automatic logic [CTR_MAX_W-1:0] ctr_dec(input logic [CTR_MAX_W-1:0] v,
                                                   input int unsigned w);
    if (v == '0) return v;
    return v - CTR_MAX_W'(1);
  endfunction

endpackage : bpred_pkg
`default_nettype wire

// File: rtl/bpred_sat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bpred_sat_ctr
// Purpose  : CTR_W-bit saturating up/down direction counter with a load port
//            used when a BTB entry is (re)allocated. Resets weakly not-taken.
// Revision : 1.0  initial release
// ============================================================================
module bpred_sat_ctr
  import bpred_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic [CTR_W-1:0] ctr
);

  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(ctr_weak_nt(CTR_W));

  logic [CTR_W-1:0] ctr_d;
  logic [CTR_W-1:0] ctr_q;

  // Next value: allocation load has priority over training
  always_comb begin
    ctr_d = ctr_q;
    if (load) begin
      ctr_d = load_val;
    end else if (inc) begin
      ctr_d = CTR_W'(ctr_inc(CTR_MAX_W'(ctr_q), CTR_W));
    end else if (dec) begin
      ctr_d = CTR_W'(ctr_dec(CTR_MAX_W'(ctr_q), CTR_W));
    end
  end

  // Counter register, async clear to weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= RST_VAL;
    else        ctr_q <= ctr_d;
  end

  assign ctr = ctr_q;

endmodule : bpred_sat_ctr
`default_nettype wire

// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_btb
// Purpose  : Direct-mapped branch target buffer with per-entry saturating
//            direction counters, bimodal or gshare indexing, an invalidation
//            sweep and a saturating mispredict counter.
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor_btb
  import bpred_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int AW      = 32,
  parameter  int CTR_W   = 2,
  parameter  int GHR_W   = 4,
  parameter  int MODE    = 0,
  parameter  int STAT_W  = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [AW-1:0]     pred_target,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [AW-1:0]     upd_pc,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic [AW-1:0]     upd_target,
  input  logic              upd_mispredict,
  input  logic              flush_all,
  output logic              busy,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int               TAG_W   = AW - IDX_W - 2;
  localparam logic [CTR_W-1:0] WEAK_TK = CTR_W'(ctr_weak_taken(CTR_W));

  // Table state
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [AW-1:0]      target_q [ENTRIES];
  logic [AW-1:0]      target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr      [ENTRIES];

  // Control state
  bp_state_e          state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [GHR_W-1:0]   ghr_q, ghr_d;
  logic [STAT_W-1:0]  mcnt_q, mcnt_d;

  // Lookup / update decode
  logic [IDX_W-1:0]   look_idx;
  logic [IDX_W-1:0]   ghr_ext;
  logic [TAG_W-1:0]   look_tag;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic               accept;

  // Word-offset bits of the PCs never participate in index or tag
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[IDX_W+1:0]};

  assign look_tag = lookup_pc[AW-1:IDX_W+2];
  assign upd_tag  = upd_pc[AW-1:IDX_W+2];
  assign busy     = (state_q == ST_SWEEP);

  // History zero-extended to index width (GHR_W may equal IDX_W)
  always_comb begin
    ghr_ext             = '0;
    ghr_ext[GHR_W-1:0]  = ghr_q;
  end

  generate
    if (MODE == MODE_BIMODAL) begin : g_bimodal
      assign look_idx = lookup_pc[IDX_W+1:2];
    end else begin : g_gshare
      assign look_idx = lookup_pc[IDX_W+1:2] ^ ghr_ext;
    end
  endgenerate

  // Same-cycle prediction from pre-update table contents; suppressed while sweeping
  always_comb begin
    pred_idx    = look_idx;
    pred_hit    = !busy && valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    pred_taken  = pred_hit && ctr[look_idx][CTR_W-1];
    pred_target = pred_hit ? target_q[look_idx] : '0;
  end

  // Update acceptance: only in IDLE, and a simultaneous flush wins
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    accept  = upd_valid && (state_q == ST_IDLE) && !flush_all;
  end

  // Table next-state: sweep clears valid bits, updates train or allocate
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (state_q == ST_SWEEP) begin
      valid_d[ptr_q] = 1'b0;
    end else if (accept && upd_taken) begin
      target_d[upd_idx] = upd_target;
      if (!upd_hit) begin
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
      end
    end
  end

  // Per-entry direction counters
  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      logic sel;
      assign sel = accept && (upd_idx == IDX_W'(i));
      bpred_sat_ctr #(
        .CTR_W (CTR_W)
      ) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sel && upd_hit && upd_taken),
        .dec      (sel && upd_hit && !upd_taken),
        .load     (sel && !upd_hit && upd_taken),
        .load_val (WEAK_TK),
        .ctr      (ctr[i])
      );
    end
  endgenerate

  // Sweep FSM: flush (re)starts at entry 0, walks every entry once
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_all) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (flush_all) begin
          ptr_d = '0;
        end else if (ptr_q == IDX_W'(ENTRIES - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Non-speculative global history and saturating mispredict statistic
  always_comb begin
    ghr_d  = ghr_q;
    mcnt_d = mcnt_q;
    if (flush_all) begin
      ghr_d = '0;
    end else if (accept) begin
      ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
    end
    if (upd_valid && upd_mispredict && (mcnt_q != '1)) begin
      mcnt_d = mcnt_q + STAT_W'(1);
    end
  end

  assign mispred_cnt = mcnt_q;

  // Table registers, async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  // Control registers, async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ghr_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      mcnt_q  <= mcnt_d;
    end
  end

endmodule : branch_predictor_btb
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_btb
// Purpose  : Directed self-checking bench for branch_predictor_btb. A bimodal
//            instance (STAT_W=4) and a gshare instance share all stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor_btb;
  import bpred_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [3:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic        flush_all = 1'b0;

  // bimodal DUT outputs
  logic        b_hit, b_taken, b_busy;
  logic [31:0] b_target;
  logic [3:0]  b_idx;
  logic [3:0]  b_mcnt;
  // gshare DUT outputs
  logic        g_hit, g_taken, g_busy;
  logic [31:0] g_target;
  logic [3:0]  g_idx;
  logic [15:0] g_mcnt;

  int n_checks = 0;
  int n_fail   = 0;
  string       tag_sb[$];
  logic [63:0] val_sb[$];

  always #5 clk = ~clk;

  branch_predictor_btb #(
    .ENTRIES(16), .AW(32), .CTR_W(2), .GHR_W(4), .MODE(MODE_BIMODAL), .STAT_W(4)
  ) u_bim (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
    .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_target), .pred_idx(b_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush_all(flush_all),
    .busy(b_busy), .mispred_cnt(b_mcnt)
  );

  branch_predictor_btb #(
    .ENTRIES(16), .AW(32), .CTR_W(2), .GHR_W(4), .MODE(MODE_GSHARE), .STAT_W(16)
  ) u_gsh (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
    .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_target), .pred_idx(g_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush_all(flush_all),
    .busy(g_busy), .mispred_cnt(g_mcnt)
  );

  task automatic expect_val(input string t, input logic [63:0] v);
    tag_sb.push_back(t);
    val_sb.push_back(v);
  endtask

  task automatic chk(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    n_checks++;
    if (tag_sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed=0x%0h required=none", obs);
    end else begin
      t = tag_sb.pop_front();
      e = val_sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $display("FAIL %s: observed=0x%0h required=0x%0h", t, obs, e);
        $error("check %s did not hold", t);
      end
    end
  endtask

  // Drive a fetch PC mid-cycle and compare the bimodal prediction
  task automatic lookup(input string t, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
    @(negedge clk);
    lookup_pc = pc;
    expect_val({t, "_hit"}, 64'(hit));
    expect_val({t, "_taken"}, 64'(taken));
    expect_val({t, "_target"}, 64'(tgt));
    #1;
    chk(64'(b_hit));
    chk(64'(b_taken));
    chk(64'(b_target));
  endtask

  // One resolved branch, held for n clock edges
  task automatic upd(input logic [31:0] pc, input logic [3:0] idx, input logic taken,
                     input logic [31:0] tgt, input logic mis, input int n);
    @(negedge clk);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_idx        = idx;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = mis;
    repeat (n) @(posedge clk);
    #1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush_all = 1'b1;
    @(posedge clk);
    #1;
    flush_all = 1'b0;
  endtask

  initial begin : stim
    int busy_cycles;

    // ---- 1: reset state, both during and after reset
    repeat (2) @(posedge clk);
    lookup("rst_in", 32'h40, 1'b0, 1'b0, 32'h0);
    expect_val("rst_busy", 64'd0);       chk(64'(b_busy));
    expect_val("rst_mcnt", 64'd0);       chk(64'(b_mcnt));
    @(negedge clk);
    rst_n = 1'b1;
    lookup("rst_out", 32'h40, 1'b0, 1'b0, 32'h0);
    expect_val("rst_out_busy", 64'd0);   chk(64'(b_busy));

    // ---- 2: allocate, train down, saturate up
    upd(32'h40, 4'd0, 1'b1, 32'h100, 1'b0, 1);
    lookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0, 1);
    upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0, 1);
    lookup("two_nt", 32'h40, 1'b1, 1'b0, 32'h100);
    repeat (4) upd(32'h40, 4'd0, 1'b1, 32'h100, 1'b0, 1);
    lookup("four_tk", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0, 1);
    lookup("sat_nt1", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0, 1);
    lookup("sat_nt2", 32'h40, 1'b1, 1'b0, 32'h100);

    // ---- 3: aliasing replacement and not-taken miss
    upd(32'h40, 4'd0, 1'b1, 32'h100, 1'b0, 1);
    upd(32'h440, 4'd0, 1'b1, 32'h200, 1'b0, 1);
    lookup("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
    lookup("alias_new", 32'h440, 1'b1, 1'b1, 32'h200);
    upd(32'h80, 4'd0, 1'b0, 32'h999, 1'b0, 1);
    lookup("nt_miss", 32'h80, 1'b0, 1'b0, 32'h0);
    lookup("nt_keep", 32'h440, 1'b1, 1'b1, 32'h200);

    // ---- 4: invalidation sweep
    upd(32'h44, 4'd1, 1'b1, 32'h300, 1'b0, 1);
    lookup("pre_flush", 32'h44, 1'b1, 1'b1, 32'h300);
    pulse_flush();
    lookup_pc      = 32'h44;
    upd_valid      = 1'b1;
    upd_pc         = 32'h48;
    upd_idx        = 4'd2;
    upd_taken      = 1'b1;
    upd_target     = 32'h400;
    upd_mispredict = 1'b1;
    @(negedge clk);
    expect_val("sweep_hit_gated", 64'd0);  chk(64'(b_hit));
    busy_cycles = b_busy ? 1 : 0;
    @(posedge clk);
    #1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!b_busy) break;
      busy_cycles++;
    end
    expect_val("busy_cycles", 64'd16);     chk(64'(busy_cycles));
    expect_val("mcnt_during_busy", 64'd1); chk(64'(b_mcnt));
    lookup("post_a", 32'h440, 1'b0, 1'b0, 32'h0);
    lookup("post_b", 32'h44, 1'b0, 1'b0, 32'h0);
    lookup("post_c", 32'h48, 1'b0, 1'b0, 32'h0);

    // ---- 5: gshare history indexing
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    upd(32'h40, 4'd0, 1'b1, 32'h100, 1'b0, 1);
    upd(32'h40, 4'd0, 1'b1, 32'h100, 1'b0, 1);
    upd(32'h40, 4'd0, 1'b0, 32'h0, 1'b0, 1);
    upd(32'h40, 4'd0, 1'b1, 32'h100, 1'b0, 1);
    lookup("bim_after", 32'h40, 1'b1, 1'b1, 32'h100);
    expect_val("bim_idx", 64'h0);          chk(64'(b_idx));
    expect_val("gsh_idx", 64'hD);          chk(64'(g_idx));
    expect_val("gsh_hit", 64'd0);          chk(64'(g_hit));

    // ---- 6: mispredict saturation and reset mid-sweep
    upd(32'h80, 4'd3, 1'b0, 32'h0, 1'b1, 14);
    @(negedge clk);
    expect_val("mcnt_14", 64'hE);          chk(64'(b_mcnt));
    expect_val("gmcnt_14", 64'hE);         chk(64'(g_mcnt));
    upd(32'h80, 4'd3, 1'b0, 32'h0, 1'b1, 5);
    @(negedge clk);
    expect_val("mcnt_sat", 64'hF);         chk(64'(b_mcnt));
    expect_val("gmcnt_19", 64'h13);        chk(64'(g_mcnt));
    pulse_flush();
    repeat (3) @(negedge clk);
    expect_val("mid_sweep_busy", 64'd1);   chk(64'(b_busy));
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("rst_busy_now", 64'd0);     chk(64'(b_busy));
    expect_val("rst_mcnt_now", 64'd0);     chk(64'(b_mcnt));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_val("rst_stays_idle", 64'd0);   chk(64'(b_busy));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_branch_predictor_btb
`default_nettype wire
